// File: rtl/wb_tag_reg_slice_pkg.sv
// wb_tag_pkg: shared FSM state encoding for the tagged Wishbone register slice
package wb_tag_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2} state_t;
endpackage

// File: rtl/wb_tag_reg_slice_if.sv
// wb_tag_reg_slice_if: classic Wishbone bus with tags; master drives request fields, slave drives response fields
interface wb_tag_reg_slice_if #(
  parameter int ADR_WIDTH = 32,
  parameter int DAT_WIDTH = 32,
  parameter int TGA_WIDTH = 4,
  parameter int TGC_WIDTH = 4,
  parameter int TGD_WIDTH = 4
);
  logic [ADR_WIDTH-1:0] adr;
  logic [DAT_WIDTH-1:0] dat_w;
  logic [DAT_WIDTH-1:0] dat_r;
  logic cyc;
  logic stb;
  logic we;
  logic [DAT_WIDTH/8-1:0] sel;
  logic ack;
  logic err;
  logic [TGA_WIDTH-1:0] tga;
  logic [TGC_WIDTH-1:0] tgc;
  logic [TGD_WIDTH-1:0] tgd_w;
  logic [TGD_WIDTH-1:0] tgd_r;
  modport master(output adr, dat_w, cyc, stb, we, sel, tga, tgc, tgd_w, input dat_r, ack, err, tgd_r);
  modport slave(input adr, dat_w, cyc, stb, we, sel, tga, tgc, tgd_w, output dat_r, ack, err, tgd_r);
endinterface

// File: rtl/wb_tag_reg_slice.sv
// wb_tag_reg_slice: registered classic Wishbone slice with tags and optional timeout; ports clock, reset (sync, active-high), s = upstream target side, m = downstream initiator side
module wb_tag_reg_slice
  import wb_tag_pkg::*;
#(
  parameter int ADR_WIDTH = 32,
  parameter int DAT_WIDTH = 32,
  parameter int TGA_WIDTH = 4,
  parameter int TGC_WIDTH = 4,
  parameter int TGD_WIDTH = 4,
  parameter int TIMEOUT = 0
) (
  input logic clock,
  input logic reset,
  wb_tag_reg_slice_if.slave s,
  wb_tag_reg_slice_if.master m
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [ADR_WIDTH-1:0] adr_q;
  logic [DAT_WIDTH-1:0] dat_w_q, dat_r_q;
  logic [DAT_WIDTH/8-1:0] sel_q;
  logic [TGA_WIDTH-1:0] tga_q;
  logic [TGC_WIDTH-1:0] tgc_q;
  logic [TGD_WIDTH-1:0] tgd_w_q, tgd_r_q;
  logic we_q, err_q, start, abort, done, expire;
  always_comb begin
    start = state == IDLE && s.cyc && s.stb;
    abort = !s.cyc;
    done = m.ack || m.err;
    expire = TIMEOUT > 0 && cnt == CW'(TIMEOUT - 1);
  end
  always_ff @(posedge clock) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state == IDLE ? (start ? REQ : IDLE)
            : state == REQ ? (abort ? IDLE : (done || expire) ? RSP : REQ)
            : IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
      adr_q <= '0;
      dat_w_q <= '0;
      dat_r_q <= '0;
      sel_q <= '0;
      we_q <= 1'b0;
      tga_q <= '0;
      tgc_q <= '0;
      tgd_w_q <= '0;
      tgd_r_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (start) begin
        cnt <= '0;
        adr_q <= s.adr;
        dat_w_q <= s.dat_w;
        sel_q <= s.sel;
        we_q <= s.we;
        tga_q <= s.tga;
        tgc_q <= s.tgc;
        tgd_w_q <= s.tgd_w;
      end
      // an upstream abort discards any response arriving in the same cycle
      if (state == REQ && !abort) begin
        if (done) begin
          dat_r_q <= m.dat_r;
          tgd_r_q <= m.tgd_r;
          err_q <= m.err;
        end else if (expire) begin
          dat_r_q <= '0;
          tgd_r_q <= '0;
          err_q <= 1'b1;
        end else cnt <= cnt + 1'b1;
      end
    end
  end
  always_comb begin
    m.cyc = state == REQ;
    m.stb = state == REQ;
    m.adr = adr_q;
    m.dat_w = dat_w_q;
    m.sel = sel_q;
    m.we = we_q;
    m.tga = tga_q;
    m.tgc = tgc_q;
    m.tgd_w = tgd_w_q;
    s.ack = state == RSP && !err_q;
    s.err = state == RSP && err_q;
    s.dat_r = dat_r_q;
    s.tgd_r = tgd_r_q;
  end
endmodule

// File: tb/tb_wb_tag_reg_slice.sv
// tb_wb_tag_reg_slice: table-driven and randomized self-checking bench for wb_tag_reg_slice
module tb_wb_tag_reg_slice;
  localparam int TO = 4;
  typedef struct {
    logic we;
    logic [31:0] adr, dat;
    logic [3:0] sel, tga, tgc, tgd;
    int lat, resp, abort_at;
    logic [31:0] rdat;
    logic [3:0] rtgd;
    int x_nreq, x_kind;
    logic [31:0] x_dat;
    logic [3:0] x_tgd;
  } vec_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] last_dat;
  logic [3:0] last_tgd;
  vec_t tbl[8];
  wb_tag_reg_slice_if up();
  wb_tag_reg_slice_if dn();
  wb_tag_reg_slice #(.TIMEOUT(TO)) dut (.clock(clock), .reset(reset), .s(up), .m(dn));
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                              input logic [3:0] sel, input logic [3:0] tga, input logic [3:0] tgc,
                              input logic [3:0] tgd, input int lat, input int resp,
                              input logic [31:0] rdat, input logic [3:0] rtgd, input int abort_at,
                              input int x_nreq, input int x_kind, input logic [31:0] x_dat,
                              input logic [3:0] x_tgd);
    vec_t v;
    v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.tga = tga; v.tgc = tgc; v.tgd = tgd;
    v.lat = lat; v.resp = resp; v.rdat = rdat; v.rtgd = rtgd; v.abort_at = abort_at;
    v.x_nreq = x_nreq; v.x_kind = x_kind; v.x_dat = x_dat; v.x_tgd = x_tgd;
    return v;
  endfunction
  // transaction-level model: lat silent cycles, then the response (0 ack, 1 err, 2 both)
  function automatic vec_t predict(input vec_t v);
    vec_t r = v;
    bit answered = v.lat < TO;
    r.x_nreq = answered ? v.lat + 1 : TO;
    if (v.abort_at > 0 && v.abort_at <= r.x_nreq) begin
      r.x_nreq = v.abort_at; r.x_kind = 0; r.x_dat = '0; r.x_tgd = '0;
    end else if (answered) begin
      r.x_kind = v.resp == 0 ? 1 : 2; r.x_dat = v.rdat; r.x_tgd = v.rtgd;
    end else begin
      r.x_kind = 2; r.x_dat = '0; r.x_tgd = '0;
    end
    return r;
  endfunction
  task automatic do_txn(input vec_t v);
    up.cyc = 1'b1; up.stb = 1'b1; up.we = v.we; up.adr = v.adr; up.dat_w = v.dat;
    up.sel = v.sel; up.tga = v.tga; up.tgc = v.tgc; up.tgd_w = v.tgd;
    tick();
    for (int k = 1; k <= v.x_nreq; k++) begin
      chk("m_cyc_stb", {dn.cyc, dn.stb}, 2'b11);
      chk("m_adr_dat", {dn.adr, dn.dat_w}, {v.adr, v.dat});
      chk("m_ctl_tags", {dn.we, dn.sel, dn.tga, dn.tgc, dn.tgd_w}, {v.we, v.sel, v.tga, v.tgc, v.tgd});
      chk("no_early_rsp", {up.ack, up.err}, 2'b00);
      up.adr = $urandom; up.dat_w = $urandom; up.we = ~up.we; up.sel = 4'($urandom);
      up.tga = 4'($urandom); up.tgc = 4'($urandom); up.tgd_w = 4'($urandom);
      if (k == v.abort_at) begin up.cyc = 1'b0; up.stb = 1'b0; end
      if (k == v.lat + 1) begin
        dn.ack = v.resp != 1; dn.err = v.resp != 0; dn.dat_r = v.rdat; dn.tgd_r = v.rtgd;
      end
      tick();
      dn.ack = 1'b0; dn.err = 1'b0; dn.dat_r = $urandom; dn.tgd_r = 4'($urandom);
    end
    chk("m_drop", {dn.cyc, dn.stb}, 2'b00);
    chk("rsp_kind", {up.ack, up.err}, v.x_kind == 1 ? 2'b10 : v.x_kind == 2 ? 2'b01 : 2'b00);
    if (v.x_kind != 0) begin last_dat = v.x_dat; last_tgd = v.x_tgd; end
    chk("s_dat_tgd", {up.dat_r, up.tgd_r}, {last_dat, last_tgd});
    up.cyc = 1'b0; up.stb = 1'b0;
    tick();
    chk("rsp_one_cycle", {up.ack, up.err, dn.cyc, dn.stb}, 4'b0000);
    chk("s_dat_hold", {up.dat_r, up.tgd_r}, {last_dat, last_tgd});
  endtask
  initial begin
    up.cyc = 0; up.stb = 0; up.we = 0; up.adr = 0; up.dat_w = 0; up.sel = 0;
    up.tga = 0; up.tgc = 0; up.tgd_w = 0;
    dn.ack = 0; dn.err = 0; dn.dat_r = 0; dn.tgd_r = 0;
    last_dat = '0; last_tgd = '0;
    tbl[0] = mk(1, 32'h2800_0010, 32'hDEADBEEF, 4'hF, 4'd3, 4'd1, 4'd2, 2, 0, 32'h0, 4'h0, 0, 3, 1, 32'h0, 4'h0);
    tbl[1] = mk(0, 32'h0000_0100, 32'h0, 4'hF, 4'd0, 4'd2, 4'd0, 0, 0, 32'h12345678, 4'h5, 0, 1, 1, 32'h12345678, 4'h5);
    tbl[2] = mk(0, 32'h0000_0200, 32'h0, 4'h3, 4'd1, 4'd0, 4'd0, 1, 2, 32'hAAAA5555, 4'hA, 0, 2, 2, 32'hAAAA5555, 4'hA);
    tbl[3] = mk(0, 32'h0000_0300, 32'h0, 4'hF, 4'd2, 4'd3, 4'd0, 9, 0, 32'h11111111, 4'h1, 0, 4, 2, 32'h0, 4'h0);
    tbl[4] = mk(0, 32'h0000_0400, 32'h0, 4'hC, 4'd4, 4'd4, 4'd0, 3, 0, 32'hCAFEF00D, 4'h6, 0, 4, 1, 32'hCAFEF00D, 4'h6);
    tbl[5] = mk(1, 32'h0000_0500, 32'h5555AAAA, 4'h1, 4'd5, 4'd5, 4'd7, 5, 0, 32'h22222222, 4'h2, 2, 2, 0, 32'h0, 4'h0);
    tbl[6] = mk(0, 32'h0000_0600, 32'h0, 4'h8, 4'd6, 4'd6, 4'd0, 0, 0, 32'h33333333, 4'h3, 1, 1, 0, 32'h0, 4'h0);
    tbl[7] = mk(1, 32'h0000_0700, 32'h01020304, 4'h6, 4'd7, 4'd7, 4'd8, 2, 1, 32'h0BADF00D, 4'h9, 0, 3, 2, 32'h0BADF00D, 4'h9);
    tick(); tick();
    chk("reset_outputs", {dn.cyc, dn.stb, dn.we, dn.sel, dn.adr, up.ack, up.err, up.dat_r}, '0);
    chk("reset_tags", {dn.dat_w, dn.tga, dn.tgc, dn.tgd_w, up.tgd_r}, '0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) do_txn(tbl[i]);
    dn.ack = 1'b1; dn.err = 1'b1;
    tick();
    chk("stray_ack_idle", {up.ack, up.err, dn.cyc, dn.stb}, 4'b0000);
    dn.ack = 1'b0; dn.err = 1'b0;
    tick();
    chk("stray_ack_after", {up.ack, up.err, dn.cyc, dn.stb}, 4'b0000);
    up.cyc = 1'b1; up.stb = 1'b1; up.adr = 32'h55; up.dat_w = 32'h66; up.sel = 4'hF; up.we = 1'b1;
    up.tga = 4'h1; up.tgc = 4'h2; up.tgd_w = 4'h3;
    tick();
    chk("pre_reset_req", {dn.cyc, dn.stb, dn.adr}, {2'b11, 32'h55});
    reset = 1'b1;
    tick();
    chk("reset_in_req", {dn.cyc, dn.stb, dn.we, dn.sel, dn.adr, up.ack, up.err, up.dat_r}, '0);
    chk("reset_in_req_tags", {dn.dat_w, dn.tga, dn.tgc, dn.tgd_w, up.tgd_r}, '0);
    reset = 1'b0; up.cyc = 1'b0; up.stb = 1'b0;
    last_dat = '0; last_tgd = '0;
    tick();
    chk("post_reset_idle", {up.ack, up.err, dn.cyc, dn.stb}, 4'b0000);
    for (int i = 0; i < 40; i++) begin
      vec_t v;
      v = mk($urandom_range(0, 1), $urandom, $urandom, 4'($urandom), 4'($urandom), 4'($urandom),
             4'($urandom), $urandom_range(0, 6), $urandom_range(0, 2), $urandom, 4'($urandom),
             $urandom_range(0, 4) == 0 ? $urandom_range(1, 6) : 0, 0, 0, 32'h0, 4'h0);
      do_txn(predict(v));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_tag_reg_slice.md
WB_TAG_REG_SLICE -- requirements
Module: wb_tag_reg_slice

Interface
REQ-001 ADR_WIDTH, 32, address width.
REQ-002 DAT_WIDTH, 32, data width; multiple of 8; SEL width = DAT_WIDTH/8.
REQ-003 TGA_WIDTH, 4, address-tag width.
REQ-004 TGC_WIDTH, 4, cycle-tag width.
REQ-005 TGD_WIDTH, 4, data-tag width (write and read).
REQ-006 TIMEOUT, 0, downstream wait-cycle limit; 0 disables timeout.
REQ-007 clock  input  1  single clock; all state on rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 s_adr  input  ADR_WIDTH  upstream address (from interconnect target port).
REQ-010 s_dat_w  input  DAT_WIDTH  upstream write data.
REQ-011 s_dat_r  output  DAT_WIDTH  registered read data to upstream.
REQ-012 s_cyc  input  1  upstream cycle.
REQ-013 s_stb  input  1  upstream strobe.
REQ-014 s_we  input  1  upstream write enable.
REQ-015 s_sel  input  DAT_WIDTH/8  upstream byte selects.
REQ-016 s_ack  output  1  upstream acknowledge pulse.
REQ-017 s_err  output  1  upstream error pulse.
REQ-018 s_tga  input  TGA_WIDTH  upstream address tag.
REQ-019 s_tgc  input  TGC_WIDTH  upstream cycle tag.
REQ-020 s_tgd_w  input  TGD_WIDTH  upstream write-data tag.
REQ-021 s_tgd_r  output  TGD_WIDTH  registered read-data tag to upstream.
REQ-022 m_adr  output  ADR_WIDTH  registered address to target.
REQ-023 m_dat_w  output  DAT_WIDTH  registered write data to target.
REQ-024 m_dat_r  input  DAT_WIDTH  target read data.
REQ-025 m_cyc  output  1  registered cycle to target.
REQ-026 m_stb  output  1  registered strobe to target.
REQ-027 m_we  output  1  registered write enable to target.
REQ-028 m_sel  output  DAT_WIDTH/8  registered byte selects to target.
REQ-029 m_ack  input  1  target acknowledge.
REQ-030 m_err  input  1  target error.
REQ-031 m_tga  output  TGA_WIDTH  registered address tag.
REQ-032 m_tgc  output  TGC_WIDTH  registered cycle tag.
REQ-033 m_tgd_w  output  TGD_WIDTH  registered write-data tag.
REQ-034 m_tgd_r  input  TGD_WIDTH  target read-data tag.

Function
REQ-035 The block SHALL implement FSM IDLE->REQ->RSP->IDLE, one transaction outstanding, classic (non-pipelined) Wishbone on both sides.
REQ-036 In IDLE with s_cyc&&s_stb, the block SHALL capture adr/dat_w/sel/we/tga/tgc/tgd_w, enter REQ, and assert m_cyc=m_stb=1 from the next cycle (1-cycle request latency); m_* fields SHALL stay stable throughout REQ.
REQ-037 In REQ, on m_ack or m_err, the block SHALL capture m_dat_r/m_tgd_r, record error = m_err (m_err wins when both are set), deassert m_cyc/m_stb on the next cycle, and enter RSP.
REQ-038 In RSP, the block SHALL assert exactly one of s_ack/s_err for exactly one cycle, with s_dat_r/s_tgd_r valid that cycle, then return to IDLE; s_dat_r/s_tgd_r SHALL hold their value until the next capture.
REQ-039 Timeout: with TIMEOUT>0, a counter SHALL clear on REQ entry and increment each REQ cycle without m_ack/m_err; on reaching TIMEOUT, the block SHALL drop m_cyc/m_stb, enter RSP with error=1 and s_dat_r=0. m_ack/m_err in the same cycle SHALL take precedence over the timeout. Counter width = $clog2(TIMEOUT+1).
REQ-040 Upstream abort: s_cyc low during REQ SHALL drop m_cyc/m_stb next cycle, return to IDLE, and produce no s_ack/s_err; a simultaneous m_ack SHALL be discarded.
REQ-041 m_ack/m_err outside REQ SHALL be ignored; s_cyc&&s_stb in REQ/RSP SHALL NOT cause a new capture.
REQ-042 Minimum round trip SHALL be 3 cycles: request edge -> m_stb -> m_ack edge -> s_ack.

Reset
REQ-043 reset SHALL force IDLE, counter=0, and all outputs to 0 (including m_cyc, m_stb, s_ack, s_err, and data/tag outputs) on the next edge, aborting any transaction without a response.

Structure
REQ-044 The FSM state encoding (IDLE=2'd0, REQ=2'd1, RSP=2'd2) SHALL live in shared package wb_tag_pkg; there SHALL be no sub-modules, with the timeout counter inline.

Verification
REQ-045 Write adr=0x2800_0010, dat=0xDEADBEEF, sel=0xF, tga=3, target acks 2 cycles after m_stb -> m_* match captured values; one s_ack pulse 1 cycle after m_ack.
REQ-046 Read, target returns m_dat_r=0x12345678, m_tgd_r=0x5 with m_ack -> s_dat_r=0x12345678, s_tgd_r=0x5, s_ack for 1 cycle.
REQ-047 m_ack and m_err asserted together -> s_err=1, s_ack=0.
REQ-048 TIMEOUT=4, target silent -> m_stb drops after 4 REQ cycles; s_err pulse with s_dat_r=0; m_ack on cycle 4 -> s_ack instead.
REQ-049 s_cyc dropped mid-REQ -> m_cyc=0 next cycle, no s_ack/s_err; reset asserted in REQ -> all outputs 0 next edge, FSM in IDLE.
